icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_array.sv | 52 +++++
 rtl/icache.sv | 139 +++++++++++++
 tb/tb_icache.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg : shared geometry, FSM encoding and tag-width helper for icache
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  localparam int INDEX_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Word-addressed lines: address bits [1:0] never reach the tag.
  function automatic int tag_bits(input int index_bits);
    return 32 - 2 - index_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ----------------------------------------------------------------------------
// icache_array : direct-mapped valid/tag/data store, one async read, one write
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  localparam int TAG_BITS  = tag_bits(INDEX_BITS),
  localparam int LINES     = 1 << INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags  [LINES];
  logic [31:0]         words [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache : direct-mapped one-word-per-line instruction cache with flush/drain
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  localparam int TAG_BITS  = tag_bits(INDEX_BITS)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        icache_in,
  output logic [31:0] icache_address_in,
  input  logic        icache_received,
  input  logic        icache_task_out,
  input  logic [31:0] value_load
);

  state_t      state, state_n;
  logic [31:0] req_pc, req_pc_n;
  logic        icache_in_n, inst_valid_n;
  logic [31:0] address_n, inst_out_n, inst_pc_n;

  logic                  rd_valid, fill, hit;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic [31:0]           word_pc;
  logic                  unused_ok;

  assign word_pc   = {fetch_pc[31:2], 2'b00};
  assign unused_ok = ^fetch_pc[1:0];

  icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk      (clk_in),
    .rst      (rst_in),
    .rd_index (fetch_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill && rdy_in),
    .wr_index (req_pc[INDEX_BITS+1:2]),
    .wr_tag   (req_pc[31:INDEX_BITS+2]),
    .wr_data  (value_load)
  );

  assign hit         = rd_valid && (rd_tag == fetch_pc[31:INDEX_BITS+2]);
  assign fetch_ready = (state == S_IDLE);

  always_comb begin
    state_n      = state;
    req_pc_n     = req_pc;
    icache_in_n  = icache_in;
    address_n    = icache_address_in;
    inst_valid_n = 1'b0;
    inst_out_n   = inst_out;
    inst_pc_n    = inst_pc;
    fill         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fetch_valid && !flush) begin
          if (hit) begin
            inst_valid_n = 1'b1;
            inst_out_n   = rd_data;
            inst_pc_n    = word_pc;
          end else begin
            state_n     = S_REQ;
            icache_in_n = 1'b1;
            address_n   = word_pc;
            req_pc_n    = word_pc;
          end
        end
      end
      S_REQ: begin
        // Once the controller has accepted, its response must be drained.
        if (flush) begin
          icache_in_n = 1'b0;
          state_n     = icache_received ? S_DRAIN : S_IDLE;
        end else if (icache_received) begin
          icache_in_n = 1'b0;
          state_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (icache_task_out) begin
          fill    = 1'b1;
          state_n = S_IDLE;
          if (!flush) begin
            inst_valid_n = 1'b1;
            inst_out_n   = value_load;
            inst_pc_n    = req_pc;
          end
        end else if (flush) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (icache_task_out) begin
          fill    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= S_IDLE;
      req_pc            <= '0;
      icache_in         <= 1'b0;
      icache_address_in <= '0;
      inst_valid        <= 1'b0;
      inst_out          <= '0;
      inst_pc           <= '0;
    end else if (rdy_in) begin
      state             <= state_n;
      req_pc            <= req_pc_n;
      icache_in         <= icache_in_n;
      icache_address_in <= address_n;
      inst_valid        <= inst_valid_n;
      inst_out          <= inst_out_n;
      inst_pc           <= inst_pc_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache : directed self-checking bench for icache (INDEX_BITS = 4)
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_valid, flush;
  logic [31:0] fetch_pc, value_load;
  logic        icache_received, icache_task_out;
  logic        fetch_ready, inst_valid, icache_in;
  logic [31:0] inst_out, inst_pc, icache_address_in;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  icache #(.INDEX_BITS(4)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_ready       (fetch_ready),
    .flush             (flush),
    .inst_valid        (inst_valid),
    .inst_out          (inst_out),
    .inst_pc           (inst_pc),
    .icache_in         (icache_in),
    .icache_address_in (icache_address_in),
    .icache_received   (icache_received),
    .icache_task_out   (icache_task_out),
    .value_load        (value_load)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one fetch; returns after the accepting edge.
  task automatic fetch(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    step();
    fetch_valid = 1'b0;
  endtask

  // Zero-wait controller: accept now, deliver the word one cycle later.
  task automatic serve(input logic [31:0] data);
    icache_received = 1'b1;
    step();
    icache_received = 1'b0;
    icache_task_out = 1'b1;
    value_load      = data;
    step();
    icache_task_out = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; fetch_valid = 1'b0; flush = 1'b0;
    fetch_pc = '0; value_load = 32'hDEAD_BEEF;
    icache_received = 1'b0; icache_task_out = 1'b0;
    step(); step();
    rst_in = 1'b0;

    check("rst_ready", fetch_ready, 1);
    check("rst_icache_in", icache_in, 0);
    check("rst_addr", icache_address_in, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);

    // Cold miss on 0x1004
    fetch(32'h0000_1004);
    check("cold_req", icache_in, 1);
    check("cold_addr", icache_address_in, 32'h0000_1004);
    check("cold_busy", fetch_ready, 0);
    step();
    check("cold_req_hold", icache_in, 1);
    serve(32'h0041_0113);
    check("cold_valid", inst_valid, 1);
    check("cold_data", inst_out, 32'h0041_0113);
    check("cold_pc", inst_pc, 32'h0000_1004);
    check("cold_idle", fetch_ready, 1);
    step();
    check("cold_pulse", inst_valid, 0);

    // Back-to-back hits (second with ignored low bits), then a miss
    fetch_valid = 1'b1; fetch_pc = 32'h0000_1004;
    step();
    check("hit1_valid", inst_valid, 1);
    check("hit1_data", inst_out, 32'h0041_0113);
    check("hit1_noreq", icache_in, 0);
    fetch_pc = 32'h0000_1006;
    step();
    check("hit2_valid", inst_valid, 1);
    check("hit2_pc", inst_pc, 32'h0000_1004);
    fetch_pc = 32'h0000_1008;
    step();
    fetch_valid = 1'b0;
    check("miss8_valid", inst_valid, 0);
    check("miss8_req", icache_in, 1);
    check("miss8_addr", icache_address_in, 32'h0000_1008);
    serve(32'h1111_2222);
    check("miss8_data", inst_out, 32'h1111_2222);

    // Conflict on index 4: 0x10 vs 0x50
    fetch(32'h0000_0010);
    check("c10_req", icache_in, 1);
    serve(32'hAAAA_0001);
    check("c10_data", inst_out, 32'hAAAA_0001);
    fetch(32'h0000_0050);
    check("c50_req", icache_in, 1);
    serve(32'hBBBB_0002);
    check("c50_pc", inst_pc, 32'h0000_0050);
    check("c50_data", inst_out, 32'hBBBB_0002);
    fetch(32'h0000_0010);
    check("c10_remiss", icache_in, 1);
    serve(32'hAAAA_0001);
    check("c10_refill", inst_out, 32'hAAAA_0001);

    // Flush in WAIT, then the word arrives through DRAIN
    fetch(32'h0000_0200);
    icache_received = 1'b1;
    step();
    icache_received = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fw_drain", fetch_ready, 0);
    check("fw_novalid", inst_valid, 0);
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0300;
    step();
    check("fw_ignored", icache_in, 0);
    fetch_valid = 1'b0;
    icache_task_out = 1'b1; value_load = 32'hCCCC_0003;
    step();
    icache_task_out = 1'b0;
    check("fw_fill_novalid", inst_valid, 0);
    check("fw_idle", fetch_ready, 1);
    fetch(32'h0000_0200);
    check("fw_hit", inst_valid, 1);
    check("fw_hit_data", inst_out, 32'hCCCC_0003);

    // Flush in REQ together with icache_received -> DRAIN
    fetch(32'h0000_0400);
    flush = 1'b1; icache_received = 1'b1;
    step();
    flush = 1'b0; icache_received = 1'b0;
    check("fr_req_clr", icache_in, 0);
    check("fr_drain", fetch_ready, 0);
    fetch_valid = 1'b1; fetch_pc = 32'h0000_1004;
    step();
    check("fr_blocked", inst_valid, 0);
    icache_task_out = 1'b1; value_load = 32'hDDDD_0004;
    step();
    icache_task_out = 1'b0;
    check("fr_fill_novalid", inst_valid, 0);
    step();
    fetch_valid = 1'b0;
    check("fr_accept", inst_valid, 1);
    check("fr_accept_data", inst_out, 32'h0041_0113);
    fetch(32'h0000_0400);
    check("fr_line_hit", inst_out, 32'hDDDD_0004);

    // Flush in REQ without acceptance -> straight back to IDLE
    fetch(32'h0000_0800);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("frq_req_clr", icache_in, 0);
    check("frq_idle", fetch_ready, 1);

    // rdy_in low holds REQ for 3 cycles despite icache_received
    fetch(32'h0000_0900);
    rdy_in = 1'b0; icache_received = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", icache_in, 1);
      check("stall_busy", fetch_ready, 0);
    end
    rdy_in = 1'b1;
    step();
    icache_received = 1'b0;
    check("stall_wait", icache_in, 0);

    // Async reset mid-WAIT
    rst_in = 1'b1;
    #1;
    check("arst_ready", fetch_ready, 1);
    check("arst_inst_out", inst_out, 0);
    check("arst_inst_pc", inst_pc, 0);
    check("arst_addr", icache_address_in, 0);
    rst_in = 1'b0;
    icache_task_out = 1'b1; value_load = 32'h5555_6666;
    step();
    icache_task_out = 1'b0;
    check("arst_late_data", inst_valid, 0);
    fetch(32'h0000_1004);
    check("arst_cleared", icache_in, 1);
    serve(32'h0041_0113);
    check("arst_refill", inst_out, 32'h0041_0113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
